// File: rtl/stack_cpu_pkg.sv
// stack_cpu_pkg: shared widths, port ids and
// arbiter state encoding for the data-memory slice.
package stack_cpu_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port signed data memory with
// synchronous write and a registered read port.
module dmem_ram
    import stack_cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic signed [DATA_W-1:0] wdata,
    output logic signed [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]         idx;
    logic                     in_range;
    logic signed [DATA_W-1:0] rdata_d;
    logic signed [DATA_W-1:0] rdata_q;

    // Decode the address; out-of-range reads yield zero.
    always_comb begin
        idx      = IDX_W'(addr);
        in_range = (32'(addr) < 32'(DEPTH));
        rdata_d  = rdata_q;
        if (en && !we) begin
            rdata_d = in_range ? mem[idx] : '0;
        end
    end

    // Array write; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (en && we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    // Read data register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter with
// bounded port locking in front of dmem_ram.
module dmem_arbiter
    import stack_cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 1024,
    parameter int MAX_LOCK = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req,
    input  logic [1:0]               we,
    input  logic [2*ADDR_W-1:0]      addr,
    input  logic [2*DATA_W-1:0]      wdata,
    input  logic [1:0]               lock,
    output logic [1:0]               gnt,
    output logic [1:0]               rvalid,
    output logic signed [DATA_W-1:0] rdata,
    output logic                     lock_active
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e               state_q, state_d;
    logic                     owner_q, owner_d;
    logic [CNT_W-1:0]         lock_cnt_q, lock_cnt_d;
    logic                     lock_block_q, lock_block_d;
    logic                     last_gnt_q, last_gnt_d;
    logic                     lock_active_q, lock_active_d;
    logic [1:0]               rvalid_q, rvalid_d;

    logic [1:0]               gnt_c;
    logic                     sel;
    logic                     force_rel;
    logic                     mem_en;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [DATA_W-1:0] mem_wdata;
    logic signed [DATA_W-1:0] mem_rdata;

    // Grant: round robin when idle, owner only when locked.
    always_comb begin
        gnt_c     = 2'b00;
        force_rel = (state_q == ARB_LOCKED) && (lock_cnt_q == CNT_MAX);
        if (!reset) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (req[PORT_CORE] &&
                        (!req[PORT_HOST] || last_gnt_q == PORT_HOST)) begin
                        gnt_c[PORT_CORE] = 1'b1;
                    end else if (req[PORT_HOST]) begin
                        gnt_c[PORT_HOST] = 1'b1;
                    end
                end
                ARB_LOCKED: begin
                    if (!force_rel && req[owner_q]) begin
                        gnt_c[owner_q] = 1'b1;
                    end
                end
            endcase
        end
        sel = gnt_c[PORT_HOST];
    end

    // Steer the granted port onto the memory.
    always_comb begin
        mem_en    = |gnt_c;
        mem_we    = we[sel];
        mem_addr  = sel ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
        mem_wdata = sel ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
    end

    // Lock FSM next state, counters and read-valid.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        lock_block_d = lock_block_q;
        last_gnt_d   = last_gnt_q;
        rvalid_d     = gnt_c & ~we;
        if (|gnt_c) begin
            last_gnt_d = sel;
        end
        if (lock_block_q && !lock[owner_q]) begin
            lock_block_d = 1'b0;
        end
        unique case (state_q)
            ARB_IDLE: begin
                if (|gnt_c && lock[sel] && !lock_block_q) begin
                    state_d    = ARB_LOCKED;
                    owner_d    = sel;
                    lock_cnt_d = CNT_ONE;
                end
            end
            ARB_LOCKED: begin
                lock_cnt_d = lock_cnt_q + CNT_ONE;
                if (force_rel) begin
                    state_d      = ARB_IDLE;
                    lock_cnt_d   = '0;
                    last_gnt_d   = owner_q;
                    lock_block_d = 1'b1;
                end else if (!lock[owner_q] &&
                             (gnt_c[owner_q] || !req[owner_q])) begin
                    state_d    = ARB_IDLE;
                    lock_cnt_d = '0;
                end
            end
        endcase
        lock_active_d = (state_d == ARB_LOCKED);
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            owner_q       <= PORT_CORE;
            lock_cnt_q    <= '0;
            lock_block_q  <= 1'b0;
            last_gnt_q    <= PORT_HOST;
            lock_active_q <= 1'b0;
            rvalid_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            lock_cnt_q    <= lock_cnt_d;
            lock_block_q  <= lock_block_d;
            last_gnt_q    <= last_gnt_d;
            lock_active_q <= lock_active_d;
            rvalid_q      <= rvalid_d;
        end
    end

    dmem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign gnt         = gnt_c;
    assign rvalid      = reset ? 2'b00 : rvalid_q;
    assign rdata       = reset ? '0 : mem_rdata;
    assign lock_active = lock_active_q;

endmodule
